// File: rtl/mod10_count_checker.sv
// Receive-side monitor for a mod-10 up/down count stream: checks +/-1 mod-10 steps,
// recovers direction, counts net decade wraps and latches a sticky error.
// Optional build macro: MOD10_CHK_HOLD_EN makes a repeated sample (hold) legal.
module mod10_count_checker #(
  parameter int DECADE_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          count_in,
  input  logic                in_valid,
  input  logic                err_clr,
  output logic                locked,
  output logic                dir,
  output logic                dir_valid,
  output logic                wrap_up,
  output logic                wrap_down,
  output logic [DECADE_W-1:0] decade_cnt,
  output logic                err,
  output logic [1:0]          err_code
);

  typedef enum logic {ACQ, TRACK} state_t;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_RANGE = 2'b01;
  localparam logic [1:0] ERR_STEP  = 2'b10;
  localparam logic [1:0] ERR_HOLD  = 2'b11;

  state_t                state, state_n;
  logic [3:0]            prev, prev_n;
  logic                  locked_n, dir_n, dir_valid_n, wrap_up_n, wrap_down_n;
  logic                  err_n;
  logic [1:0]            err_code_n, cause;
  logic [DECADE_W-1:0]   decade_n;
  logic [3:0]            up_exp, dn_exp;
  logic                  out_of_range;

  assign up_exp       = (prev == 4'd9) ? 4'd0 : prev + 4'd1;
  assign dn_exp       = (prev == 4'd0) ? 4'd9 : prev - 4'd1;
  assign out_of_range = (count_in > 4'd9);

  // NOTE: every signal is given its hold/default value first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_n     = state;
    prev_n      = prev;
    locked_n    = locked;
    dir_n       = dir;
    dir_valid_n = dir_valid;
    wrap_up_n   = 1'b0;
    wrap_down_n = 1'b0;
    decade_n    = decade_cnt;
    err_n       = err;
    err_code_n  = err_code;
    cause       = ERR_NONE;

    // Clear is applied first so an error detected in the same cycle overrides it.
    if (err_clr) begin
      err_n      = 1'b0;
      err_code_n = ERR_NONE;
    end

    if (in_valid) begin
      if (out_of_range) begin
        cause = ERR_RANGE;
      end else if (state == ACQ) begin
        prev_n      = count_in;
        state_n     = TRACK;
        locked_n    = 1'b1;
        dir_valid_n = 1'b0;
      end else if (count_in == up_exp) begin
        prev_n      = count_in;
        dir_n       = 1'b1;
        dir_valid_n = 1'b1;
        if (prev == 4'd9) begin
          wrap_up_n = 1'b1;
          decade_n  = decade_cnt + DECADE_W'(1);
        end
      end else if (count_in == dn_exp) begin
        prev_n      = count_in;
        dir_n       = 1'b0;
        dir_valid_n = 1'b1;
        if (prev == 4'd0) begin
          wrap_down_n = 1'b1;
          decade_n    = decade_cnt - DECADE_W'(1);
        end
      end else if (count_in == prev) begin
`ifdef MOD10_CHK_HOLD_EN
        prev_n = prev;
`else
        cause = ERR_HOLD;
`endif
      end else begin
        cause = ERR_STEP;
      end
    end

    // The offending sample is discarded: prev, dir and decade count are untouched.
    if (cause != ERR_NONE) begin
      err_n       = 1'b1;
      err_code_n  = cause;
      locked_n    = 1'b0;
      dir_valid_n = 1'b0;
      state_n     = ACQ;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ACQ;
      prev       <= 4'd0;
      locked     <= 1'b0;
      dir        <= 1'b0;
      dir_valid  <= 1'b0;
      wrap_up    <= 1'b0;
      wrap_down  <= 1'b0;
      decade_cnt <= '0;
      err        <= 1'b0;
      err_code   <= ERR_NONE;
    end else begin
      state      <= state_n;
      prev       <= prev_n;
      locked     <= locked_n;
      dir        <= dir_n;
      dir_valid  <= dir_valid_n;
      wrap_up    <= wrap_up_n;
      wrap_down  <= wrap_down_n;
      decade_cnt <= decade_n;
      err        <= err_n;
      err_code   <= err_code_n;
    end
  end

endmodule

// File: tb/tb_mod10_count_checker.sv
// Self-checking bench for mod10_count_checker: directed scenarios plus randomized
// stimulus, every cycle compared against an arithmetic reference model.
module tb_mod10_count_checker;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    count_in = '0;
  logic          in_valid = 1'b0;
  logic          err_clr = 1'b0;
  logic          locked, dir, dir_valid, wrap_up, wrap_down, err;
  logic [DW-1:0] decade_cnt;
  logic [1:0]    err_code;

  mod10_count_checker #(.DECADE_W(DW)) dut (
    .clk(clk), .rst(rst), .count_in(count_in), .in_valid(in_valid), .err_clr(err_clr),
    .locked(locked), .dir(dir), .dir_valid(dir_valid), .wrap_up(wrap_up),
    .wrap_down(wrap_down), .decade_cnt(decade_cnt), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state, written in terms of decimal digits and integer tallies.
  bit m_locked, m_dir, m_dv, m_wu, m_wd, m_err;
  int m_prev, m_dec, m_code;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    m_locked = 0; m_dir = 0; m_dv = 0; m_wu = 0; m_wd = 0; m_err = 0;
    m_prev = 0; m_dec = 0; m_code = 0;
  endtask

  task automatic model_step(input bit v, input int c, input bit clr, input bit r);
    int ec;
    if (r) begin
      model_reset();
      return;
    end
    m_wu = 0; m_wd = 0; ec = 0;
    if (clr) begin m_err = 0; m_code = 0; end
    if (v) begin
      if (c > 9) ec = 1;
      else if (!m_locked) begin m_locked = 1; m_dv = 0; m_prev = c; end
      else if (c == (m_prev + 1) % 10) begin
        m_dir = 1; m_dv = 1;
        if (m_prev == 9) begin m_wu = 1; m_dec = (m_dec + 1) % (1 << DW); end
        m_prev = c;
      end else if (c == (m_prev + 9) % 10) begin
        m_dir = 0; m_dv = 1;
        if (m_prev == 0) begin m_wd = 1; m_dec = (m_dec + (1 << DW) - 1) % (1 << DW); end
        m_prev = c;
      end else if (c == m_prev) begin
`ifndef MOD10_CHK_HOLD_EN
        ec = 3;
`endif
      end else ec = 2;
      if (ec != 0) begin m_err = 1; m_code = ec; m_locked = 0; m_dv = 0; end
    end
  endtask

  task automatic compare_all();
    check("locked",     32'(locked),     32'(m_locked));
    check("dir",        32'(dir),        32'(m_dir));
    check("dir_valid",  32'(dir_valid),  32'(m_dv));
    check("wrap_up",    32'(wrap_up),    32'(m_wu));
    check("wrap_down",  32'(wrap_down),  32'(m_wd));
    check("decade_cnt", 32'(decade_cnt), 32'(m_dec));
    check("err",        32'(err),        32'(m_err));
    check("err_code",   32'(err_code),   32'(m_code));
  endtask

  // Drive one cycle of inputs, advance the model at the edge, compare #1 later.
  task automatic step(input bit v, input int c, input bit clr = 0, input bit r = 0);
    in_valid = v; count_in = 4'(c); err_clr = clr; rst = r;
    @(posedge clk);
    model_step(v, c, clr, r);
    #1;
    compare_all();
  endtask

  task automatic feed(input int seq[]);
    foreach (seq[i]) step(1, seq[i]);
  endtask

  initial begin
    model_reset();
    step(0, 0, 0, 1);
    step(1, 5, 1, 1);                       // reset beats in_valid and err_clr
    check("reset_locked", 32'(locked), 32'd0);

    feed('{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1});
    check("up_decade", 32'(decade_cnt), 32'd1);
    check("up_dir", 32'(dir), 32'd1);

    step(0, 0, 0, 1);
    feed('{3, 2, 1, 0, 9, 8});
    check("down_decade", 32'(decade_cnt), 32'hFF);
    check("down_err", 32'(err), 32'd0);

    step(0, 0, 0, 1);
    feed('{4, 5, 7});
    check("step_code", 32'(err_code), 32'b10);
    check("step_locked", 32'(locked), 32'd0);
    feed('{2, 3});
    check("relock_err_sticky", 32'(err), 32'd1);
    step(0, 0, 1);
    check("clr_code", 32'(err_code), 32'd0);
    step(1, 12);
    check("range_code", 32'(err_code), 32'b01);
    feed('{5, 6});
    check("range_relock_dir", 32'(dir), 32'd1);
    step(1, 9, 1);                          // error and clear in the same cycle
    check("clr_vs_err", 32'(err_code), 32'b10);

    step(0, 0, 0, 1);
    feed('{6, 6});
`ifdef MOD10_CHK_HOLD_EN
    check("hold_locked", 32'(locked), 32'd1);
`else
    check("hold_code", 32'(err_code), 32'b11);
`endif

    step(0, 0, 0, 1);
    feed('{7, 8});
    step(1, 3, 1, 1);
    check("mid_rst_locked", 32'(locked), 32'd0);
    feed('{2, 1});
    check("mid_rst_dir", 32'(dir), 32'd0);
    check("mid_rst_err", 32'(err), 32'd0);

    step(0, 0, 0, 1);
    step(1, 9);
    for (int k = 0; k < 256; k++)
      for (int d = 0; d < 10; d++) step(1, d);
    check("wrap256", 32'(decade_cnt), 32'd0);

    for (int i = 0; i < 4000; i++) begin
      int sel, c;
      bit v, clr, r;
      sel = $urandom_range(0, 99);
      if (sel < 35)      c = (m_prev + 1) % 10;
      else if (sel < 70) c = (m_prev + 9) % 10;
      else if (sel < 80) c = m_prev;
      else               c = $urandom_range(0, 15);
      v   = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 19) == 0);
      r   = ($urandom_range(0, 199) == 0);
      step(v, c, clr, r);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
